// File: rtl/arb_pkg.sv
// Shared arbiter package: limits, weight type, decision kinds, one-hot decode.
package arb_pkg;

  localparam int ARB_MAX_REQS = 32;
  localparam int ARB_WEIGHT_W = 4;

  typedef logic [ARB_WEIGHT_W-1:0] weight_t;

  // Per-cycle decision taken by the weighted round-robin top level.
  typedef enum logic [2:0] {
    DEC_HOLD,
    DEC_LOCK,
    DEC_CONT,
    DEC_ARB,
    DEC_IDLE
  } dec_e;

  function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_REQS-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ARB_MAX_REQS; i++)
      if (oh[i]) idx = idx | i;
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority pick: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQS = 4
) (
  input  logic [NUM_REQS-1:0] reqs,
  input  logic [NUM_REQS-1:0] ptr,
  output logic [NUM_REQS-1:0] winner
);

  logic [2*NUM_REQS-1:0] reqs2;
  logic [2*NUM_REQS-1:0] ptr2;
  logic [2*NUM_REQS-1:0] hit;
  logic                  carry;
  logic                  live;

  assign reqs2 = {reqs, reqs};
  assign ptr2  = {{NUM_REQS{1'b0}}, ptr};

  // The wrap carry[0]=carry[NUM_REQS] is realised by running the chain over two
  // copies of the request vector, which keeps the netlist free of a comb loop.
  always_comb begin
    carry = 1'b0;
    live  = 1'b0;
    hit   = '0;
    for (int i = 0; i < 2*NUM_REQS; i++) begin
      live   = carry | ptr2[i];
      hit[i] = reqs2[i] & live;
      carry  = ~reqs2[i] & live;
    end
  end

  assign winner = hit[NUM_REQS-1:0] | hit[2*NUM_REQS-1:NUM_REQS];

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with registered one-hot grants and accept handshake.
// Optional feature: define WRR_ARBITER_LOCK_EN to add a 'lock' input that pins the grant.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS-1:0]          reqs,
  input  logic [NUM_REQS*WEIGHT_W-1:0] weights,
  input  logic                         grant_ready,
`ifdef WRR_ARBITER_LOCK_EN
  input  logic                         lock,
`endif
  output logic [NUM_REQS-1:0]          grants,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQS)-1:0]  grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0]     ptr, ptr_nxt;
  logic [WEIGHT_W-1:0]     credit, credit_nxt;
  logic [NUM_REQS-1:0]     grants_nxt;
  logic [NUM_REQS-1:0]     winner;
  logic [WEIGHT_W-1:0]     wsel;
  logic [ARB_MAX_REQS-1:0] gpad;
  logic                    cur_req;
  logic                    advance;
  logic                    lock_hold;
  dec_e                    dec;

  rr_pick #(.NUM_REQS(NUM_REQS)) u_pick (
    .reqs   (reqs),
    .ptr    (ptr),
    .winner (winner)
  );

  assign grant_valid = |grants;
  assign cur_req     = |(reqs & grants);
  assign advance     = !grant_valid || grant_ready;

`ifdef WRR_ARBITER_LOCK_EN
  assign lock_hold = grant_valid && cur_req && lock;
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    wsel = '0;
    for (int i = 0; i < NUM_REQS; i++)
      if (winner[i]) wsel = wsel | weights[i*WEIGHT_W +: WEIGHT_W];
  end

  always_comb begin
    dec = DEC_HOLD;
    if (advance) begin
      if (lock_hold)                                 dec = DEC_LOCK;
      else if (grant_valid && cur_req && credit != '0) dec = DEC_CONT;
      else if (|reqs)                                dec = DEC_ARB;
      else                                           dec = DEC_IDLE;
    end
  end

  always_comb begin
    grants_nxt = grants;
    credit_nxt = credit;
    ptr_nxt    = ptr;
    case (dec)
      DEC_CONT: credit_nxt = credit - 1'b1;
      DEC_ARB: begin
        grants_nxt = winner;
        credit_nxt = wsel;
        ptr_nxt    = {winner[NUM_REQS-2:0], winner[NUM_REQS-1]};
      end
      DEC_IDLE: begin
        grants_nxt = '0;
        credit_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grants <= '0;
      credit <= '0;
      ptr    <= NUM_REQS'(1);
    end else begin
      grants <= grants_nxt;
      credit <= credit_nxt;
      ptr    <= ptr_nxt;
    end
  end

  always_comb begin
    gpad                 = '0;
    gpad[NUM_REQS-1:0]   = grants;
  end

  assign grant_idx = IDX_W'(onehot_to_idx(gpad));

endmodule
